// File: rtl/poly_uniform_eta_stream_pkg.sv
// Shared constants and state encoding for the uniform-eta polynomial sampler.
// The sampler rejection-samples nibbles from a SHAKE256 squeeze stream.
package poly_uniform_eta_stream_pkg;

  localparam int unsigned N       = 256;
  localparam int unsigned SEED_W  = 512;
  localparam int unsigned NONCE_W = 16;
  localparam int unsigned MSG_W   = NONCE_W + SEED_W;

  localparam int unsigned ETA2 = 2;
  localparam int unsigned ETA4 = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHash,
    StLoad,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/eta_nibble_decode.sv
// Combinational rejection test and coefficient map for one 4-bit nibble.
// The coefficient is returned as a 4-bit two's-complement value.
module eta_nibble_decode
  import poly_uniform_eta_stream_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       eta_sel,
  output logic       accept,
  output logic [3:0] coef
);

  logic [3:0] mod5;

  always_comb begin
    // Nibble is below 15 whenever it is accepted, so two subtractions suffice.
    if (nibble >= 4'd10) begin
      mod5 = nibble - 4'd10;
    end else if (nibble >= 4'd5) begin
      mod5 = nibble - 4'd5;
    end else begin
      mod5 = nibble;
    end

    if (eta_sel) begin
      accept = (nibble < 4'd9);
      coef   = 4'(ETA4) - nibble;
    end else begin
      accept = (nibble < 4'd15);
      coef   = 4'(ETA2) - mod5;
    end
  end

endmodule

// File: rtl/poly_uniform_eta_stream.sv
// Samples N coefficients in [-eta, eta] from an external SHAKE256 squeeze stream.
// Each byte yields up to two candidates (low nibble first); rejected nibbles are skipped.
module poly_uniform_eta_stream
  import poly_uniform_eta_stream_pkg::*;
#(
  parameter int unsigned N      = poly_uniform_eta_stream_pkg::N,
  parameter int unsigned COEF_W = 32,
  parameter int unsigned IN_W   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  eta_sel,
  input  logic [SEED_W-1:0]     seed,
  input  logic [NONCE_W-1:0]    nonce,
  output logic                  hash_start,
  output logic [MSG_W-1:0]      hash_msg,
  output logic                  hash_stop,
  input  logic [IN_W-1:0]       sq_data,
  input  logic                  sq_valid,
  output logic                  sq_ready,
  output logic [N*COEF_W-1:0]   a_out,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned BYTES = IN_W / 8;
  localparam int unsigned PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BYTES - 1);

  state_e             state_q;
  logic               eta_q;
  logic [MSG_W-1:0]   msg_q;
  logic [IN_W-1:0]    beat_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [COEF_W-1:0]  coef_q [N];
  logic               done_q;
  logic               hash_start_q;
  logic               hash_stop_q;
  logic               sq_ready_q;

  logic [7:0]         cur_byte;
  logic               acc0, acc1;
  logic [3:0]         c0, c1;
  logic               wr1;
  logic [CNT_W-1:0]   pos1;
  logic [CNT_W-1:0]   count_nxt;

  function automatic logic [COEF_W-1:0] sext4(input logic [3:0] v);
    return {{(COEF_W - 4){v[3]}}, v};
  endfunction

  eta_nibble_decode u_dec_lo (
    .nibble  (cur_byte[3:0]),
    .eta_sel (eta_q),
    .accept  (acc0),
    .coef    (c0)
  );

  eta_nibble_decode u_dec_hi (
    .nibble  (cur_byte[7:4]),
    .eta_sel (eta_q),
    .accept  (acc1),
    .coef    (c1)
  );

  always_comb begin
    cur_byte  = beat_q[{ptr_q, 3'b000} +: 8];
    pos1      = count_q + CNT_W'(acc0);
    // The high nibble is dropped if the low nibble already filled the last slot.
    wr1       = acc1 && (pos1 < CNT_W'(N));
    count_nxt = pos1 + CNT_W'(wr1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      eta_q        <= 1'b0;
      msg_q        <= '0;
      beat_q       <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      hash_start_q <= 1'b0;
      hash_stop_q  <= 1'b0;
      sq_ready_q   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      hash_start_q <= 1'b0;
      hash_stop_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            eta_q        <= eta_sel;
            msg_q        <= {nonce, seed};
            count_q      <= '0;
            ptr_q        <= '0;
            hash_start_q <= 1'b1;
            state_q      <= StHash;
            for (int i = 0; i < int'(N); i++) begin
              coef_q[i] <= '0;
            end
          end
        end
        StHash: begin
          sq_ready_q <= 1'b1;
          state_q    <= StLoad;
        end
        StLoad: begin
          if (sq_valid) begin
            beat_q     <= sq_data;
            ptr_q      <= '0;
            sq_ready_q <= 1'b0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (acc0) begin
            coef_q[count_q[IDX_W-1:0]] <= sext4(c0);
          end
          if (wr1) begin
            coef_q[pos1[IDX_W-1:0]] <= sext4(c1);
          end
          count_q <= count_nxt;
          if (count_nxt == CNT_W'(N)) begin
            hash_stop_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else if (ptr_q == PTR_LAST) begin
            sq_ready_q <= 1'b1;
            state_q    <= StLoad;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        StDone: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_aout
    assign a_out[COEF_W*g +: COEF_W] = coef_q[g];
  end

  assign hash_start = hash_start_q;
  assign hash_msg   = msg_q;
  assign hash_stop  = hash_stop_q;
  assign sq_ready   = sq_ready_q;
  assign done       = done_q;

endmodule

// File: tb/tb_poly_uniform_eta_stream.sv
// Scoreboard bench for poly_uniform_eta_stream: directed squeeze streams with
// hand-derived coefficient vectors, hash handshakes, timing and reset behaviour.
module tb_poly_uniform_eta_stream;

  localparam int unsigned N      = 256;
  localparam int unsigned COEF_W = 32;
  localparam int unsigned IN_W   = 64;
  localparam int unsigned AW     = N * COEF_W;

  typedef logic [AW-1:0] avec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              eta_sel;
  logic [511:0]      seed;
  logic [15:0]       nonce;
  logic              hash_start;
  logic [527:0]      hash_msg;
  logic              hash_stop;
  logic [IN_W-1:0]   sq_data;
  logic              sq_valid;
  logic              sq_ready;
  avec_t             a_out;
  logic              done;

  always #5 clock = ~clock;

  poly_uniform_eta_stream #(
    .N      (N),
    .COEF_W (COEF_W),
    .IN_W   (IN_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .eta_sel    (eta_sel),
    .seed       (seed),
    .nonce      (nonce),
    .hash_start (hash_start),
    .hash_msg   (hash_msg),
    .hash_stop  (hash_stop),
    .sq_data    (sq_data),
    .sq_valid   (sq_valid),
    .sq_ready   (sq_ready),
    .a_out      (a_out),
    .done       (done)
  );

  int total = 0;
  int bad = 0;
  int hstart_cnt = 0;
  int hstop_cnt = 0;

  logic [IN_W-1:0] beat_src[$];
  logic [527:0]    exp_msg_q[$];
  avec_t           exp_a_q[$];

  logic [527:0] em;
  avec_t        ea;
  avec_t        ev;
  logic         done_prev = 1'b0;
  int           fi;
  int           cyc;
  int           snap;
  bit           seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic avec_t fill2(input logic [31:0] even_v, input logic [31:0] odd_v);
    avec_t v;
    for (int i = 0; i < int'(N); i++) begin
      v[COEF_W*i +: COEF_W] = (i % 2 == 0) ? even_v : odd_v;
    end
    return v;
  endfunction

  task automatic push_beats(input logic [7:0] b, input int n);
    repeat (n) beat_src.push_back({8{b}});
  endtask

  task automatic start_job(input logic es, input logic [15:0] nn, input logic [511:0] sd);
    eta_sel = es;
    nonce   = nn;
    seed    = sd;
    exp_msg_q.push_back({nn, sd});
    start   = 1'b1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: done=%0b after %0d cycles, required done=1", name, done, n);
    end
  endtask

  // Squeeze source: a beat leaves the queue only after a sampled handshake.
  initial begin : feeder
    bit fire;
    sq_valid = 1'b0;
    sq_data  = '0;
    forever begin
      @(negedge clock);
      fire = sq_valid && sq_ready;
      @(posedge clock);
      #1;
      if (fire && beat_src.size() > 0) void'(beat_src.pop_front());
      if (beat_src.size() > 0) begin
        sq_valid = 1'b1;
        sq_data  = beat_src[0];
      end else begin
        sq_valid = 1'b0;
        sq_data  = '0;
      end
    end
  end

  // Monitor: hash handshake and finished polynomials are checked against the scoreboard.
  always @(negedge clock) begin
    if (hash_stop === 1'b1) hstop_cnt++;
    if (hash_start === 1'b1) begin
      hstart_cnt++;
      total++;
      if (exp_msg_q.size() == 0) begin
        bad++;
        $display("FAIL hash_msg: hash_start with empty scoreboard, required none");
      end else begin
        em = exp_msg_q.pop_front();
        if (hash_msg !== em) begin
          bad++;
          $display("FAIL hash_msg: got nonce %0h seed_lo %0h expected nonce %0h seed_lo %0h",
                   hash_msg[527:512], hash_msg[63:0], em[527:512], em[63:0]);
        end
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      total++;
      if (exp_a_q.size() == 0) begin
        bad++;
        $display("FAIL a_out: done with empty scoreboard, required none");
      end else begin
        ea = exp_a_q.pop_front();
        if (a_out !== ea) begin
          bad++;
          fi = 0;
          for (int i = int'(N) - 1; i >= 0; i--) begin
            if (a_out[COEF_W*i +: COEF_W] !== ea[COEF_W*i +: COEF_W]) fi = i;
          end
          $display("FAIL a_out: coef[%0d] got %0h expected %0h", fi,
                   a_out[COEF_W*fi +: COEF_W], ea[COEF_W*fi +: COEF_W]);
        end
      end
    end
    done_prev = done;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset   = 1'b1;
    start   = 1'b0;
    eta_sel = 1'b0;
    seed    = '0;
    nonce   = '0;

    // ETA 2, all-zero bytes: every nibble maps to +2, 16 beats at 9 cycles each.
    push_beats(8'h00, 16);
    exp_a_q.push_back(fill2(32'd2, 32'd2));
    tick(3);
    check("reset done", done, 0);
    check("reset hash_start", hash_start, 0);
    check("reset hash_stop", hash_stop, 0);
    check("reset sq_ready", sq_ready, 0);
    check("reset a_out nonzero", |a_out, 0);

    reset = 1'b0;
    start_job(1'b0, 16'h0001, {8{64'h0123_4567_89ab_cdef}});
    wait_done("eta2 zeros", cyc);
    check("eta2 zeros cycles", cyc, 146);
    start = 1'b0;
    tick(3);
    check("eta2 zeros hash_stop count", hstop_cnt, 1);
    check("eta2 zeros idle sq_ready", sq_ready, 0);
    check("eta2 zeros idle done", done, 0);

    // ETA 2, 0x8E: t0=14 -> -2, t1=8 -> -1.
    push_beats(8'h8e, 16);
    exp_a_q.push_back(fill2(32'hffff_fffe, 32'hffff_ffff));
    tick(1);
    start_job(1'b0, 16'h0002, {16{32'hdead_beef}});
    wait_done("eta2 8e", cyc);
    start = 1'b0;
    tick(2);

    // ETA 4, 0x8E: t0=14 rejected, t1=8 -> -4; one coefficient per byte.
    push_beats(8'h8e, 32);
    exp_a_q.push_back(fill2(32'hffff_fffc, 32'hffff_fffc));
    tick(1);
    start_job(1'b1, 16'h0003, {64{8'h5a}});
    wait_done("eta4 8e", cyc);
    start = 1'b0;
    tick(2);
    check("eta4 8e hash_stop count", hstop_cnt, 3);

    // ETA 2, a fully rejected 0xFF beat costs one beat time and writes nothing.
    push_beats(8'hff, 1);
    push_beats(8'h00, 16);
    exp_a_q.push_back(fill2(32'd2, 32'd2));
    tick(1);
    start_job(1'b0, 16'h0004, {512{1'b1}});
    wait_done("eta2 ff skip", cyc);
    check("eta2 ff skip cycles", cyc, 155);
    start = 1'b0;
    tick(2);

    // ETA 4: 254 coefs from zero bytes, 0xF0 gives coef 254, then 0x33 ends at 255.
    push_beats(8'h00, 15);
    beat_src.push_back(64'hf000_0000_0000_0000);
    beat_src.push_back(64'h7777_7777_7777_7733);
    ev = fill2(32'd4, 32'd4);
    ev[COEF_W*255 +: COEF_W] = 32'd1;
    exp_a_q.push_back(ev);
    snap = hstop_cnt;
    tick(1);
    start_job(1'b1, 16'h0005, {8{64'hfeed_f00d_0000_0001}});
    wait_done("eta4 last slot", cyc);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sq_ready) seen = 1'b1;
    end
    check("eta4 last slot sq_ready after done", seen, 0);
    check("eta4 last slot hash_stop pulses", hstop_cnt - snap, 1);
    check("eta4 last slot done held", done, 1);
    start = 1'b0;
    tick(2);

    // Reset mid-scan once 50 zero bytes (100 coefs) have been consumed.
    push_beats(8'h00, 16);
    tick(1);
    snap = hstop_cnt;
    start_job(1'b0, 16'h0006, {16{32'h1357_9bdf}});
    tick(59);
    check("busy coef99", a_out[COEF_W*99 +: COEF_W], 32'd2);
    check("busy coef100", a_out[COEF_W*100 +: COEF_W], 32'd0);
    check("busy done", done, 0);
    reset = 1'b1;
    start = 1'b0;
    tick(1);
    check("mid reset done", done, 0);
    check("mid reset a_out nonzero", |a_out, 0);
    check("mid reset sq_ready", sq_ready, 0);
    reset = 1'b0;
    beat_src.delete();
    tick(3);
    check("mid reset no hash_stop", hstop_cnt - snap, 0);

    // Fresh job after reset: ETA 4, 0x10 -> t0=0 gives +4, t1=1 gives +3.
    push_beats(8'h10, 16);
    exp_a_q.push_back(fill2(32'd4, 32'd3));
    tick(1);
    start_job(1'b1, 16'h0007, {8{64'h0f0f_0f0f_f0f0_f0f0}});
    wait_done("after reset", cyc);

    // start held through DONE: no restart until start has dropped for a cycle.
    snap = hstart_cnt;
    tick(10);
    check("held start done", done, 1);
    check("held start no restart", hstart_cnt - snap, 0);
    start = 1'b0;
    tick(1);
    check("start low idle", done, 0);
    push_beats(8'h00, 16);
    exp_a_q.push_back(fill2(32'd2, 32'd2));
    start_job(1'b0, 16'hbeef, {8{64'h8888_4444_2222_1111}});
    wait_done("restart", cyc);
    check("restart hash_start count", hstart_cnt - snap, 1);
    start = 1'b0;
    tick(3);

    check("msg scoreboard drained", exp_msg_q.size(), 0);
    check("a_out scoreboard drained", exp_a_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
